// File: rtl/io_in_capture_pkg.sv
// Shared constants for io_in_capture: register map, CTRL/STATUS bit positions
// and default parameters.
package io_in_capture_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
  localparam int          DEF_NCH       = 20;
  localparam int          DEF_CNT_W     = 16;

  localparam logic [3:0] OFS_SAMPLE = 4'h0;
  localparam logic [3:0] OFS_COUNT  = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  // word index within the window, i.e. offset[3:2]
  typedef enum logic [1:0] {
    REG_SAMPLE = 2'd0,
    REG_COUNT  = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_idx_e;

  localparam int CTRL_CH_W     = 5;
  localparam int CTRL_EN_BIT   = 8;
  localparam int CTRL_CLR_BIT  = 9;
  localparam int STAT_OVF_BIT  = 0;
  localparam int STAT_PEND_BIT = 1;

  typedef struct packed {
    logic                 en;
    logic [CTRL_CH_W-1:0] ch_sel;
  } ctrl_t;

endpackage

// File: rtl/io_in_capture_sync.sv
// Two-flop synchronizer for asynchronous pad inputs, one chain per bit.
module io_in_capture_sync #(
  parameter int W = 1
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_in_capture.sv
// Wishbone-mapped rising-edge counter on one selectable io_in channel.
// Optional irq output enabled by macro IO_IN_CAPTURE_IRQ_EN.
module io_in_capture
  import io_in_capture_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          NCH       = DEF_NCH,
  parameter int          CNT_W     = DEF_CNT_W
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic [NCH-1:0] io_in,
  output logic           irq
);

  logic [NCH-1:0]   synced, prev;
  logic [31:0]      synced_x, prev_x, rdata;
  logic [CNT_W-1:0] count;
  ctrl_t            ctrl;
  logic             ovf, pend;
  logic             hit, wr, sel_ok, edge_det, clr, cnt_ev, cnt_sat;
  logic             w1c_ovf, w1c_pend;
  reg_idx_e         idx;

  io_in_capture_sync #(.W(NCH)) u_sync (
    .gclk   (wb_clk_i),
    .grst_n (wb_rst_ni),
    .d      (io_in),
    .q      (synced)
  );

  // Every channel keeps its own previous value, so a CH_SEL switch compares
  // the new channel against its own history and cannot fake an edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) prev <= '0;
    else            prev <= synced;
  end

  assign synced_x = 32'(synced);
  assign prev_x   = 32'(prev);
  assign sel_ok   = 32'(ctrl.ch_sel) < 32'(NCH);
  assign edge_det = sel_ok & synced_x[ctrl.ch_sel] & ~prev_x[ctrl.ch_sel];

  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign idx = reg_idx_e'(wbs_adr_i[3:2]);
  assign wr  = wbs_ack_o & hit & wbs_we_i;

  assign clr      = wr & (idx == REG_CTRL)   & wbs_sel_i[1] & wbs_dat_i[CTRL_CLR_BIT];
  assign w1c_ovf  = wr & (idx == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_OVF_BIT];
  assign w1c_pend = wr & (idx == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_PEND_BIT];
  assign cnt_ev   = edge_det & ctrl.en & ~clr;
  assign cnt_sat  = &count;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      count <= '0;
      ctrl  <= '0;
      ovf   <= 1'b0;
      pend  <= 1'b0;
    end else begin
      if (clr)                   count <= '0;
      else if (cnt_ev & ~cnt_sat) count <= count + CNT_W'(1);
      if (wr && idx == REG_CTRL) begin
        if (wbs_sel_i[0]) ctrl.ch_sel <= wbs_dat_i[CTRL_CH_W-1:0];
        if (wbs_sel_i[1]) ctrl.en     <= wbs_dat_i[CTRL_EN_BIT];
      end
      // a set event in the same cycle as W1C wins
      ovf  <= (ovf  & ~w1c_ovf)  | (cnt_ev & cnt_sat);
      pend <= (pend & ~w1c_pend) | cnt_ev;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      REG_SAMPLE: rdata = synced_x;
      REG_COUNT:  rdata = 32'(count);
      REG_CTRL: begin
        rdata[CTRL_CH_W-1:0] = ctrl.ch_sel;
        rdata[CTRL_EN_BIT]   = ctrl.en;
      end
      REG_STATUS: begin
        rdata[STAT_OVF_BIT]  = ovf;
        rdata[STAT_PEND_BIT] = pend;
      end
      default: rdata = '0;
    endcase
  end

  // ack blocks itself for one cycle so a held stb still yields 2-cycle accesses
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= hit & ~wbs_ack_o;
      wbs_dat_o <= (hit & ~wbs_ack_o) ? rdata : '0;
    end
  end

`ifdef IO_IN_CAPTURE_IRQ_EN
  assign irq = pend & ctrl.en;
`else
  assign irq = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_sel_i[3:2],
                         wbs_dat_i[31:10], wbs_dat_i[7:5]};

endmodule

// File: tb/tb_io_in_capture.sv
// Bench for io_in_capture: two instances (16-bit and 4-bit counters) share one
// bus at different base addresses; expectations come from a per-instance model.
module tb_io_in_capture;
  import io_in_capture_pkg::*;

  localparam int          NCH    = 20;
  localparam logic [31:0] BASE_A = 32'h3000_0000;
  localparam logic [31:0] BASE_B = 32'h3000_0010;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]      sel = 4'h0;
  logic [31:0]     adr = '0, wdat = '0;
  logic            ack_a, ack_b, irq_a, irq_b;
  logic [31:0]     dat_a, dat_b;
  logic [NCH-1:0]  io_in = '0;
  int              checks = 0, errors = 0;
  logic            irq_seen = 1'b0;

  always #5 clk = ~clk;

  io_in_capture #(.BASE_ADDR(BASE_A)) dut_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack_a), .wbs_dat_o(dat_a), .io_in(io_in), .irq(irq_a));

  io_in_capture #(.BASE_ADDR(BASE_B), .CNT_W(4)) dut_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack_b), .wbs_dat_o(dat_b), .io_in(io_in), .irq(irq_b));

  // reference model, index 0 = dut_a, 1 = dut_b
  int          m_cnt[2];
  int          m_max[2] = '{65535, 15};
  int          m_ch[2];
  bit          m_en[2], m_ovf[2], m_pend[2];
  logic [31:0] base[2] = '{BASE_A, BASE_B};

  always @(negedge clk) if (irq_a | irq_b) irq_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_ch[i] = 0; m_en[i] = 0; m_ovf[i] = 0; m_pend[i] = 0;
    end
  endtask

  function automatic logic [31:0] exp_ctrl(input int i);
    return (32'(m_en[i]) << 8) | 32'(m_ch[i]);
  endfunction

  function automatic logic [31:0] exp_status(input int i);
    return {30'd0, m_pend[i], m_ovf[i]};
  endfunction

  function automatic logic exp_irq(input int i);
`ifdef IO_IN_CAPTURE_IRQ_EN
    return m_pend[i] & m_en[i];
`else
    return 1'b0;
`endif
  endfunction

  // one Wishbone access: ack must come exactly one cycle after stb and last one cycle
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd);
    @(posedge clk); #1;
    adr = a; we = w; wdat = d; sel = be; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("ack_rise", 32'(ack_a | ack_b), 32'd1);
    rd = dat_a | dat_b;
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(ack_a | ack_b), 32'd0);
    chk("dat_idle", dat_a | dat_b, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    xfer(a, 1'b0, 32'd0, 4'hF, rd);
    chk(tag, rd, exp);
  endtask

  task automatic wr_ctrl(input int i, input logic [31:0] d);
    logic [31:0] rd;
    xfer(base[i] + 32'(OFS_CTRL), 1'b1, d, 4'hF, rd);
    m_ch[i] = int'(d[4:0]);
    m_en[i] = d[8];
    if (d[9]) m_cnt[i] = 0;
  endtask

  task automatic pulse(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      io_in[ch] = 1'b1; repeat (4) @(posedge clk); #1;
      io_in[ch] = 1'b0; repeat (4) @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++)
      if (m_en[i] && m_ch[i] == ch && ch < NCH && n > 0) begin
        if (m_cnt[i] + n > m_max[i]) m_ovf[i] = 1;
        m_cnt[i] = (m_cnt[i] + n > m_max[i]) ? m_max[i] : m_cnt[i] + n;
        m_pend[i] = 1;
      end
  endtask

  task automatic chk_all(input int i, input string tag);
    rd_chk({tag, "_count"},  base[i] + 32'(OFS_COUNT),  32'(m_cnt[i]));
    rd_chk({tag, "_status"}, base[i] + 32'(OFS_STATUS), exp_status(i));
    rd_chk({tag, "_ctrl"},   base[i] + 32'(OFS_CTRL),   exp_ctrl(i));
    chk({tag, "_irq"}, 32'(i == 0 ? irq_a : irq_b), 32'(exp_irq(i)));
  endtask

  initial begin
    logic [31:0]    rd;
    logic [NCH-1:0] v;
    int             n;
    model_reset();

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_ack", 32'(ack_a | ack_b), 32'd0);
    chk("rst_dat", dat_a | dat_b, 32'd0);
    chk("rst_irq", 32'(irq_a | irq_b), 32'd0);
    rst_n = 1'b1;
    chk_all(0, "rst_a");
    chk_all(1, "rst_b");

    // an address outside both windows gets no ack
    @(posedge clk); #1;
    adr = 32'h4000_0008; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("miss_no_ack", 32'(ack_a | ack_b), 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;

    // pads
    io_in = 20'hA5A5A;
    repeat (3) @(posedge clk); #1;
    rd_chk("sample_a5a5a", BASE_A + 32'(OFS_SAMPLE), 32'h000A_5A5A);
    for (int k = 0; k < 3; k++) begin
      v = NCH'($urandom);
      io_in = v;
      repeat (3) @(posedge clk); #1;
      rd_chk("sample_rand", BASE_B + 32'(OFS_SAMPLE), 32'(v));
    end
    io_in = NCH'($urandom) & ~NCH'(32'h18);

    // writes to read-only registers are acked and ignored
    xfer(BASE_A + 32'(OFS_SAMPLE), 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
    xfer(BASE_A + 32'(OFS_COUNT),  1'b1, 32'hFFFF_FFFF, 4'hF, rd);
    rd_chk("sample_ro", BASE_A + 32'(OFS_SAMPLE), 32'(io_in));
    rd_chk("count_ro",  BASE_A + 32'(OFS_COUNT),  32'd0);

    // counting on channel 3
    wr_ctrl(0, 32'h103);
    pulse(3, 5);
    chk_all(0, "count5");
    n = $urandom_range(1, 8);
    pulse(3, n);
    chk_all(0, "count_rand");

    // EN=0: edges ignored, irq masked
    wr_ctrl(0, 32'h003);
    pulse(3, $urandom_range(1, 4));
    chk_all(0, "en_off");

    // byte lane 0 only: CH_SEL changes, EN byte untouched
    xfer(BASE_A + 32'(OFS_CTRL), 1'b1, 32'h0000_0107, 4'h1, rd);
    m_ch[0] = 7;
    rd_chk("sel_byte0", BASE_A + 32'(OFS_CTRL), exp_ctrl(0));
    wr_ctrl(0, 32'h000);

    // saturation on the 4-bit instance
    wr_ctrl(1, 32'h103);
    pulse(3, 17);
    chk_all(1, "sat");
    xfer(BASE_B + 32'(OFS_STATUS), 1'b1, 32'h3, 4'hF, rd);
    m_ovf[1] = 0; m_pend[1] = 0;
    chk_all(1, "sat_w1c");
    wr_ctrl(1, 32'h000);

    // CLR write committing in the same cycle as an edge: edge dropped
    wr_ctrl(0, 32'h103);
    pulse(3, 2);
    @(posedge clk); #1;
    io_in[3] = 1'b1;
    wr_ctrl(0, 32'h303);
    repeat (4) @(posedge clk); #1;
    io_in[3] = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk_all(0, "clr_edge");

    // STATUS W1C in the same cycle as an edge: PEND stays set
    xfer(BASE_A + 32'(OFS_STATUS), 1'b1, 32'h2, 4'hF, rd);
    m_pend[0] = 0;
    rd_chk("pend_cleared", BASE_A + 32'(OFS_STATUS), exp_status(0));
    @(posedge clk); #1;
    io_in[3] = 1'b1;
    xfer(BASE_A + 32'(OFS_STATUS), 1'b1, 32'h2, 4'hF, rd);
    m_cnt[0]++; m_pend[0] = 1;
    repeat (4) @(posedge clk); #1;
    io_in[3] = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk_all(0, "w1c_edge");

    // switch to a channel already held high: no false edge
    io_in[4] = 1'b1;
    repeat (4) @(posedge clk); #1;
    wr_ctrl(0, 32'h104);
    repeat (6) @(posedge clk); #1;
    chk_all(0, "chsel_switch");
    io_in[4] = 1'b0;
    repeat (4) @(posedge clk); #1;
    pulse(4, 2);
    chk_all(0, "ch4_pulses");

    // CH_SEL = NCH selects nothing
    wr_ctrl(0, 32'h100 | 32'(NCH));
    pulse(3, 2);
    pulse(0, 2);
    chk_all(0, "chsel_oob");

    // reset in the middle of an access: no ack, everything cleared
    wr_ctrl(0, 32'h103);
    @(posedge clk); #1;
    adr = BASE_A + 32'(OFS_COUNT); we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_mid_no_ack", 32'(ack_a | ack_b), 32'd0);
    end
    chk("rst_mid_dat", dat_a | dat_b, 32'd0);
    chk("rst_mid_irq", 32'(irq_a | irq_b), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_all(0, "post_rst_a");
    chk_all(1, "post_rst_b");

`ifndef IO_IN_CAPTURE_IRQ_EN
    chk("irq_tied_low", 32'(irq_seen), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
